// File: rtl/func3_chk_pkg.sv
// rtl/func3_chk_pkg.sv - shared types and constants for the func3 response checker
package func3_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam int NUM_VEC = 16;

  localparam logic [7:0] MISR_POLY = 8'h1D;
  localparam logic [7:0] MISR_SEED = 8'hFF;

  // Response as sampled from func3: {z,y}
  typedef logic [1:0] resp_t;

  // One MISR step: shift left, fold in the polynomial on carry-out, xor the response
  function automatic logic [7:0] misr_step(input logic [7:0] s, input resp_t r);
    return {s[6:0], 1'b0} ^ (s[7] ? MISR_POLY : 8'h00) ^ {6'b0, r};
  endfunction

endpackage

// File: rtl/func3_chk_misr.sv
// rtl/func3_chk_misr.sv - 8-bit MISR compressing the func3 response stream
module func3_chk_misr
  import func3_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       seed,
  input  logic       en,
  input  resp_t      din,
  output logic [7:0] sig
);

  logic [7:0] sig_q;
  logic [7:0] sig_d;

  // Seed has priority so a new sweep always starts from a known signature
  always_comb begin
    sig_d = sig_q;
    if (seed) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  // Signature register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/func3_resp_checker.sv
// rtl/func3_resp_checker.sv - closed-loop sweep checker for func3; FUNC3_CHK_SIG_EN adds the sig MISR
module func3_resp_checker
  import func3_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [31:0] EXP_TABLE   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_err_idx,
`ifdef FUNC3_CHK_SIG_EN
  output logic [7:0] sig,
`endif
  output logic       err_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] IDX_LAST  = 4'(NUM_VEC - 1);

  chk_state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [3:0] first_err_idx_q, first_err_idx_d;
  logic       err_valid_q, err_valid_d;

  logic  start_go;
  logic  sample;
  resp_t resp;
  resp_t exp_resp;

  assign start_go = start && (state_q != RUN);
  assign sample   = (state_q == RUN) && (hold_cnt_q == HOLD_LAST);
  assign resp     = {z, y};
  assign exp_resp = EXP_TABLE[{idx_q, 1'b0} +: 2];

  // Sweep sequencing, hold counting and mismatch bookkeeping
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    hold_cnt_d      = hold_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    err_valid_d     = err_valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = RUN;
          idx_d           = '0;
          hold_cnt_d      = '0;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          err_valid_d     = 1'b0;
        end
      end
      RUN: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (sample) begin
          if (resp != exp_resp) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (!err_valid_q) begin
              first_err_idx_d = idx_q;
              err_valid_d     = 1'b1;
            end
          end
          hold_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      hold_cnt_q      <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      err_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      hold_cnt_q      <= hold_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      err_valid_q     <= err_valid_d;
    end
  end

  // Stimulus is only driven while sweeping; IDLE and DONE park it at zero
  assign {a, b, c, d}  = (state_q == RUN) ? idx_q : 4'b0000;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (err_cnt_q == 5'd0);
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign err_valid     = err_valid_q;

`ifdef FUNC3_CHK_SIG_EN
  func3_chk_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .seed (start_go),
    .en   (sample),
    .din  (resp),
    .sig  (sig)
  );
`endif

endmodule

// File: tb/tb_func3_resp_checker.sv
// tb/tb_func3_resp_checker.sv - directed self-checking bench for func3_resp_checker
module tb_func3_resp_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a, b, c, d;
  logic       y, z;
  logic       busy, done, pass, err_valid;
  logic [4:0] err_cnt;
  logic [3:0] first_err_idx;
`ifdef FUNC3_CHK_SIG_EN
  logic [7:0] sig;
  logic [7:0] clean_sig;
`endif

  int n_cmp;
  int n_err;
  int mode;   // 0 clean, 1 z inverted at vector 5, 2 y stuck at 0
  int busy_cycles;

  func3_resp_checker #(
    .HOLD_CYCLES (2),
    .EXP_TABLE   (32'h7D28_2828)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .y             (y),
    .z             (z),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
`ifdef FUNC3_CHK_SIG_EN
    .sig           (sig),
`endif
    .err_valid     (err_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback func3 model with fault injection
  assign y = (mode == 2) ? 1'b0 : (a & b);
  assign z = (c ^ d) ^ ((mode == 1) && ({a, b, c, d} == 4'd5));

  function automatic logic [16:0] all_outs();
    return {a, b, c, d, busy, done, pass, err_valid, err_cnt, first_err_idx};
  endfunction

  function automatic logic [7:0] misr_model(input int m);
    logic [7:0] s;
    logic [3:0] v;
    logic       ry, rz;
    s = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      v  = 4'(i);
      ry = (m == 2) ? 1'b0 : (v[3] & v[2]);
      rz = (v[1] ^ v[0]) ^ ((m == 1) && (i == 5));
      s  = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, rz, ry};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start, count busy cycles until done; optional extra start pulse at cycle mid
  task automatic run_sweep(input int mid, output int bcyc);
    bit finished;
    finished = 0;
    bcyc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      start = (n == mid);
      if (busy) bcyc++;
      else if (done) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    check("sweep_finished", 32'(finished), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(all_outs()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", 32'(all_outs()), 32'd0);

    // Clean sweep
    mode = 0;
    run_sweep(-1, busy_cycles);
    check("clean_busy_cycles", 32'(busy_cycles), 32'd32);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);
    check("clean_err_valid", 32'(err_valid), 32'd0);
    check("clean_stim_zero", 32'({a, b, c, d}), 32'd0);
`ifdef FUNC3_CHK_SIG_EN
    clean_sig = sig;
    check("clean_sig", 32'(sig), 32'(misr_model(0)));
`endif

    // Single z fault at vector 5
    mode = 1;
    run_sweep(-1, busy_cycles);
    check("zfault_err_cnt", 32'(err_cnt), 32'd1);
    check("zfault_first_idx", 32'(first_err_idx), 32'd5);
    check("zfault_pass", 32'(pass), 32'd0);
    check("zfault_err_valid", 32'(err_valid), 32'd1);
`ifdef FUNC3_CHK_SIG_EN
    check("zfault_sig", 32'(sig), 32'(misr_model(1)));
    check("zfault_sig_differs", 32'(sig != clean_sig), 32'd1);
`endif

    // y stuck at 0
    mode = 2;
    run_sweep(-1, busy_cycles);
    check("ystuck_err_cnt", 32'(err_cnt), 32'd4);
    check("ystuck_first_idx", 32'(first_err_idx), 32'd12);
    check("ystuck_err_valid", 32'(err_valid), 32'd1);
    check("ystuck_pass", 32'(pass), 32'd0);

    // Restart from DONE clears results
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done_low", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_err_cnt", 32'(err_cnt), 32'd0);
    check("restart_err_valid", 32'(err_valid), 32'd0);
    check("restart_first_idx", 32'(first_err_idx), 32'd0);
    begin
      bit fin;
      fin = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (done) begin
          fin = 1;
          break;
        end
      end
      check("restart_finished", 32'(fin), 32'd1);
      check("restart_pass", 32'(pass), 32'd1);
    end

    // start mid-RUN is ignored
    run_sweep(10, busy_cycles);
    check("midstart_busy_cycles", 32'(busy_cycles), 32'd32);
    check("midstart_pass", 32'(pass), 32'd1);

    // Reset at cycle 13 of a sweep, after the vector-5 fault was recorded
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_err_cnt", 32'(err_cnt), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_outs", 32'(all_outs()), 32'd0);
`ifdef FUNC3_CHK_SIG_EN
    check("midreset_sig", 32'(sig), 32'd0);
`endif
    @(negedge clk);
    rst  = 1'b0;
    mode = 0;
    run_sweep(-1, busy_cycles);
    check("post_reset_busy_cycles", 32'(busy_cycles), 32'd32);
    check("post_reset_pass", 32'(pass), 32'd1);
    check("post_reset_err_cnt", 32'(err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
